// File: rtl/accum_bank_pkg.sv
// Shared types and helpers for the accum_bank multi-channel accumulator.
package accum_bank_pkg;

   localparam int unsigned DEF_NUM_CH    = 4;
   localparam int unsigned DEF_IN_WIDTH  = 8;
   localparam int unsigned DEF_OUT_WIDTH = 16;
   localparam int unsigned DEF_INC_MULT  = 3;

   // Saturation limits are built at this width, then truncated to OUT_WIDTH.
   localparam int unsigned SAT_W = 64;

   typedef enum logic [1:0] {
      OP_NONE = 2'd0,
      OP_ADD  = 2'd1,
      OP_CLR  = 2'd2
   } op_kind_e;

   // Two operands of equal sign producing a result of the other sign.
   function automatic logic signed_ovf(input logic a_sign, input logic b_sign, input logic r_sign);
      return (a_sign == b_sign) && (r_sign != a_sign);
   endfunction

   // Most-positive value of a w-bit two's-complement number.
   function automatic logic [SAT_W-1:0] sat_pos(input int unsigned w);
      return (SAT_W'(1) << (w - 1)) - SAT_W'(1);
   endfunction

   // Most-negative value of a w-bit two's-complement number (valid after truncation to w).
   function automatic logic [SAT_W-1:0] sat_neg(input int unsigned w);
      return ~sat_pos(w);
   endfunction

endpackage

// File: rtl/accum_bank_operand.sv
// Stage 1 of accum_bank: builds the signed update operand and registers it with its channel.
module accum_bank_operand
   import accum_bank_pkg::*;
#(
   parameter int unsigned NUM_CH    = DEF_NUM_CH,
   parameter int unsigned IN_WIDTH  = DEF_IN_WIDTH,
   parameter int unsigned OUT_WIDTH = DEF_OUT_WIDTH,
   parameter int unsigned INC_MULT  = DEF_INC_MULT
) (
   input  logic                      clk,
   input  logic                      clr,
   input  logic                      inc,
   input  logic [IN_WIDTH-1:0]       inc_val,
   input  logic                      dec,
   input  logic [IN_WIDTH-1:0]       dec_val,
   input  logic [$clog2(NUM_CH)-1:0] ch,
   input  logic                      clr_ch,
   output op_kind_e                  kind_q,
   output logic [OUT_WIDTH-1:0]      op_q,
   output logic [$clog2(NUM_CH)-1:0] chan_q,
   output logic                      valid_q
);

   localparam int unsigned EXT_W = OUT_WIDTH - IN_WIDTH;
   localparam logic [OUT_WIDTH-1:0] MULT = OUT_WIDTH'(INC_MULT);

   logic [OUT_WIDTH-1:0]      inc_ext;
   logic [OUT_WIDTH-1:0]      dec_ext;
   op_kind_e                  kind_d;
   logic [OUT_WIDTH-1:0]      op_d;
   logic [$clog2(NUM_CH)-1:0] chan_d;
   logic                      valid_d;

   // Operand selection: clear beats increment beats decrement.
   always_comb begin
      inc_ext = {{EXT_W{inc_val[IN_WIDTH-1]}}, inc_val};
      dec_ext = {{EXT_W{dec_val[IN_WIDTH-1]}}, dec_val};
      kind_d  = OP_NONE;
      op_d    = '0;
      chan_d  = ch;
      valid_d = 1'b0;
      if (clr_ch) begin
         kind_d  = OP_CLR;
         valid_d = 1'b1;
      end else if (inc) begin
         kind_d  = OP_ADD;
         op_d    = OUT_WIDTH'(inc_ext * MULT);
         valid_d = 1'b1;
      end else if (dec) begin
         kind_d  = OP_ADD;
         op_d    = OUT_WIDTH'(-dec_ext);
         valid_d = 1'b1;
      end
   end

   // Stage-1 pipeline register; clr drops any pending update.
   always_ff @(posedge clk) begin
      if (clr) begin
         kind_q  <= OP_NONE;
         op_q    <= '0;
         chan_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         kind_q  <= kind_d;
         op_q    <= op_d;
         chan_q  <= chan_d;
         valid_q <= valid_d;
      end
   end

endmodule

// File: rtl/accum_bank.sv
// Multi-channel signed up/down accumulator bank, 2-stage pipeline, sticky overflow flags.
// Build option: define ACCUM_BANK_SATURATE_EN to clamp on overflow instead of wrapping.
module accum_bank
   import accum_bank_pkg::*;
#(
   parameter int unsigned NUM_CH    = DEF_NUM_CH,
   parameter int unsigned IN_WIDTH  = DEF_IN_WIDTH,
   parameter int unsigned OUT_WIDTH = DEF_OUT_WIDTH,
   parameter int unsigned INC_MULT  = DEF_INC_MULT
) (
   input  logic                      clk,
   input  logic                      clr,
   input  logic                      inc,
   input  logic [IN_WIDTH-1:0]       incVal,
   input  logic                      dec,
   input  logic [IN_WIDTH-1:0]       decVal,
   input  logic [$clog2(NUM_CH)-1:0] ch,
   input  logic                      clr_ch,
   input  logic [$clog2(NUM_CH)-1:0] rd_ch,
   output logic [OUT_WIDTH-1:0]      rd_q,
   output logic [NUM_CH-1:0]         ovf,
   output logic                      busy
);

   localparam int unsigned CH_W = $clog2(NUM_CH);

`ifdef ACCUM_BANK_SATURATE_EN
   localparam logic [OUT_WIDTH-1:0] SAT_MAX = OUT_WIDTH'(sat_pos(OUT_WIDTH));
   localparam logic [OUT_WIDTH-1:0] SAT_MIN = OUT_WIDTH'(sat_neg(OUT_WIDTH));
`endif

   op_kind_e             kind_s1;
   logic [OUT_WIDTH-1:0] op_s1;
   logic [CH_W-1:0]      chan_s1;
   logic                 valid_s1;

   logic [OUT_WIDTH-1:0] acc_q [NUM_CH];
   logic [OUT_WIDTH-1:0] acc_d [NUM_CH];
   logic [NUM_CH-1:0]    ovf_q;
   logic [NUM_CH-1:0]    ovf_d;
   logic [OUT_WIDTH-1:0] rd_d;
   logic [OUT_WIDTH:0]   sum;
   logic [OUT_WIDTH-1:0] res;
   logic                 ov;

   accum_bank_operand #(
      .NUM_CH    (NUM_CH),
      .IN_WIDTH  (IN_WIDTH),
      .OUT_WIDTH (OUT_WIDTH),
      .INC_MULT  (INC_MULT)
   ) u_operand (
      .clk     (clk),
      .clr     (clr),
      .inc     (inc),
      .inc_val (incVal),
      .dec     (dec),
      .dec_val (decVal),
      .ch      (ch),
      .clr_ch  (clr_ch),
      .kind_q  (kind_s1),
      .op_q    (op_s1),
      .chan_q  (chan_s1),
      .valid_q (valid_s1)
   );

`ifndef ACCUM_BANK_SATURATE_EN
   // The extra sum bit only steers clamping; wrap mode keeps the low bits.
   logic unused_sum_msb;
   assign unused_sum_msb = sum[OUT_WIDTH];
`endif

   // Stage 2: read-modify-write of the target channel, plus read-back select.
   always_comb begin
      acc_d = acc_q;
      ovf_d = ovf_q;
      rd_d  = acc_q[rd_ch];
      sum   = {acc_q[chan_s1][OUT_WIDTH-1], acc_q[chan_s1]} + {op_s1[OUT_WIDTH-1], op_s1};
      ov    = signed_ovf(acc_q[chan_s1][OUT_WIDTH-1], op_s1[OUT_WIDTH-1], sum[OUT_WIDTH-1]);
      res   = sum[OUT_WIDTH-1:0];
`ifdef ACCUM_BANK_SATURATE_EN
      if (ov) begin
         res = sum[OUT_WIDTH] ? SAT_MIN : SAT_MAX;
      end
`endif
      case (kind_s1)
         OP_ADD: begin
            acc_d[chan_s1] = res;
            if (ov) begin
               ovf_d[chan_s1] = 1'b1;
            end
         end
         OP_CLR: begin
            acc_d[chan_s1] = '0;
            ovf_d[chan_s1] = 1'b0;
         end
         default: begin
         end
      endcase
   end

   // Accumulator, overflow and read-back registers.
   always_ff @(posedge clk) begin
      if (clr) begin
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            acc_q[i] <= '0;
         end
         ovf_q <= '0;
         rd_q  <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            acc_q[i] <= acc_d[i];
         end
         ovf_q <= ovf_d;
         rd_q  <= rd_d;
      end
   end

   assign ovf  = ovf_q;
   assign busy = valid_s1;

endmodule

// File: tb/tb_accum_bank.sv
// Self-checking bench for accum_bank: directed plan plus randomized traffic against an integer model.
module tb_accum_bank;

   localparam int MULT = 3;
   localparam int MAXV = 32767;
   localparam int MINV = -32768;

   bit          clk = 1'b0;
   logic        clr, inc, dec, clr_ch;
   logic [7:0]  incVal, decVal;
   logic [1:0]  ch, rd_ch;
   logic [15:0] rd_q;
   logic [3:0]  ovf;
   logic        busy;

   accum_bank dut (
      .clk    (clk),
      .clr    (clr),
      .inc    (inc),
      .incVal (incVal),
      .dec    (dec),
      .decVal (decVal),
      .ch     (ch),
      .clr_ch (clr_ch),
      .rd_ch  (rd_ch),
      .rd_q   (rd_q),
      .ovf    (ovf),
      .busy   (busy)
   );

   always #5 clk = ~clk;

   // Model state: integer accumulators plus one pending (stage-1) operation.
   int          m_acc [4];
   bit          m_ovf [4];
   bit          p_valid, p_clr;
   int          p_op, p_ch;
   logic [15:0] exp_rd;
   logic [3:0]  exp_ovf;
   logic        exp_busy;
   bit          check_en = 1'b0;

   int n_cmp = 0;
   int n_err = 0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endfunction

   // Advance the model by one clock edge using the inputs the DUT just sampled.
   task automatic model_edge();
      int s;
      if (clr) begin
         for (int i = 0; i < 4; i++) begin
            m_acc[i] = 0;
            m_ovf[i] = 1'b0;
         end
         p_valid  = 1'b0;
         exp_rd   = '0;
         check_en = 1'b1;
      end else begin
         exp_rd = 16'(m_acc[rd_ch]);
         if (p_valid) begin
            if (p_clr) begin
               m_acc[p_ch] = 0;
               m_ovf[p_ch] = 1'b0;
            end else begin
               s = m_acc[p_ch] + p_op;
               if (s > MAXV || s < MINV) begin
                  m_ovf[p_ch] = 1'b1;
`ifdef ACCUM_BANK_SATURATE_EN
                  s = (s > MAXV) ? MAXV : MINV;
`else
                  s = (s > MAXV) ? s - 65536 : s + 65536;
`endif
               end
               m_acc[p_ch] = s;
            end
         end
         p_valid = clr_ch || inc || dec;
         p_clr   = clr_ch;
         p_ch    = int'(ch);
         p_op    = inc ? int'($signed(incVal)) * MULT : -int'($signed(decVal));
      end
      exp_busy = p_valid;
      for (int i = 0; i < 4; i++) exp_ovf[i] = m_ovf[i];
   endtask

   // Drive one cycle of inputs, let the edge happen, return at the following negedge.
   task automatic step(input logic c_clr, input logic c_inc, input logic [7:0] iv,
                       input logic c_dec, input logic [7:0] dv, input logic [1:0] c_ch,
                       input logic c_clrch, input logic [1:0] c_rd);
      clr = c_clr; inc = c_inc; incVal = iv; dec = c_dec; decVal = dv;
      ch = c_ch; clr_ch = c_clrch; rd_ch = c_rd;
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic idle(input logic [1:0] c_rd);
      step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 2'd0, 1'b0, c_rd);
   endtask

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (check_en) begin
         chk("rd_q", 32'(rd_q), 32'(exp_rd));
         chk("ovf", 32'(ovf), 32'(exp_ovf));
         chk("busy", 32'(busy), 32'(exp_busy));
      end
   end

   initial begin
      logic [7:0] iv, dv;
      logic       c_inc, c_dec, c_clrch, c_clr;

      // 1: reset and read back every channel
      step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 2'd0, 1'b0, 2'd0);
      step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 2'd0, 1'b0, 2'd0);
      for (int i = 0; i < 4; i++) begin
         idle(2'(i));
         chk("t1_rd_zero", 32'(rd_q), 32'h0);
      end
      chk("t1_ovf", 32'(ovf), 32'h0);
      chk("t1_busy", 32'(busy), 32'h0);

      // 2: single increment, latency and busy width
      step(1'b0, 1'b1, 8'h05, 1'b0, 8'h00, 2'd0, 1'b0, 2'd0);
      chk("t2_busy_hi", 32'(busy), 32'h1);
      idle(2'd0);
      chk("t2_busy_lo", 32'(busy), 32'h0);
      chk("t2_rd_early", 32'(rd_q), 32'h0);
      idle(2'd0);
      chk("t2_rd", 32'(rd_q), 32'h000F);

      // 3: back-to-back dec then inc on channel 1
      step(1'b0, 1'b0, 8'h00, 1'b1, 8'hFE, 2'd1, 1'b0, 2'd1);
      step(1'b0, 1'b1, 8'hFF, 1'b0, 8'h00, 2'd1, 1'b0, 2'd1);
      idle(2'd1);
      chk("t3_rd_first", 32'(rd_q), 32'h0002);
      idle(2'd1);
      chk("t3_rd_second", 32'(rd_q), 32'hFFFF);

      // 4: drive channel 2 up to and past the positive limit
      for (int i = 0; i < 86; i++) step(1'b0, 1'b1, 8'h7F, 1'b0, 8'h00, 2'd2, 1'b0, 2'd2);
      idle(2'd2);
      idle(2'd2);
      chk("t4_rd_limit", 32'(rd_q), 32'h7FFE);
      chk("t4_ovf_clear", 32'(ovf[2]), 32'h0);
      step(1'b0, 1'b1, 8'h7F, 1'b0, 8'h00, 2'd2, 1'b0, 2'd2);
      idle(2'd2);
      idle(2'd2);
`ifdef ACCUM_BANK_SATURATE_EN
      chk("t4_rd_over", 32'(rd_q), 32'h7FFF);
`else
      chk("t4_rd_over", 32'(rd_q), 32'h817B);
`endif
      chk("t4_ovf_set", 32'(ovf[2]), 32'h1);

      // 5: inc priority over dec, then clr_ch beats a same-cycle inc
      step(1'b0, 1'b1, 8'h01, 1'b1, 8'h01, 2'd3, 1'b0, 2'd3);
      idle(2'd3);
      idle(2'd3);
      chk("t5_rd_inc_prio", 32'(rd_q), 32'h0003);
      step(1'b0, 1'b1, 8'h01, 1'b0, 8'h00, 2'd3, 1'b1, 2'd3);
      idle(2'd3);
      idle(2'd3);
      chk("t5_rd_cleared", 32'(rd_q), 32'h0000);
      chk("t5_ovf", 32'(ovf), 32'b0100);

      // 6: clr right behind an increment discards it
      step(1'b0, 1'b1, 8'h05, 1'b0, 8'h00, 2'd0, 1'b0, 2'd0);
      step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 2'd0, 1'b0, 2'd0);
      chk("t6_busy", 32'(busy), 32'h0);
      chk("t6_ovf", 32'(ovf), 32'h0);
      idle(2'd0);
      idle(2'd0);
      chk("t6_rd", 32'(rd_q), 32'h0);

      // Randomized traffic, biased toward large increments so overflow occurs.
      for (int n = 0; n < 3000; n++) begin
         c_clr   = ($urandom_range(0, 299) == 0);
         c_clrch = ($urandom_range(0, 19) == 0);
         c_inc   = ($urandom_range(0, 1) == 0);
         c_dec   = ($urandom_range(0, 2) == 0);
         iv      = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h7F;
         dv      = ($urandom_range(0, 3) == 0) ? 8'h80 : 8'($urandom);
         step(c_clr, c_inc, iv, c_dec, dv, 2'($urandom), c_clrch, 2'($urandom));
      end
      idle(2'd0);
      idle(2'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/accum_bank.md
Name: accum_bank

Overview:
- Multi-channel signed up/down accumulator bank with a 2-stage pipeline.
- NUM_CH independent accumulators, each updated by sign-extended increments (scaled by INC_MULT) or decrements.
- Provides a registered read-back port and sticky per-channel overflow flags.
- Sits behind the timing-lab stimulus logic; it is the generalised, pipelined successor of the single-channel up/down counter.

Parameters:
- NUM_CH, 4, number of accumulator channels (power of 2, ≥2).
- IN_WIDTH, 8, width of incVal/decVal (two's complement).
- OUT_WIDTH, 16, accumulator width; must be ≥ IN_WIDTH + $clog2(INC_MULT) + 1.
- INC_MULT, 3, unsigned constant multiplier applied to incVal (≥1).

Ports:
- clk  in  1  clock
- clr  in  1  synchronous active-high reset; clears all state
- inc  in  1  increment strobe
- incVal  in  IN_WIDTH  signed increment operand
- dec  in  1  decrement strobe
- decVal  in  IN_WIDTH  signed decrement operand
- ch  in  $clog2(NUM_CH)  target channel for inc/dec
- clr_ch  in  1  clear one channel (channel given by ch)
- rd_ch  in  $clog2(NUM_CH)  read-back channel select
- rd_q  out  OUT_WIDTH  registered value of accumulator rd_ch
- ovf  out  NUM_CH  sticky overflow flag per channel
- busy  out  1  stage-1 holds a valid pending update

Behaviour:
- Single clock clk; clr synchronous, active-high, sampled on posedge clk, highest priority.
- Reset: all accumulators 0, rd_q=0, ovf=0, busy=0, pipeline valid bits 0. clr mid-pipeline discards any in-flight update.
- Stage 1 (cycle N): on inc or dec, register op, target channel, and valid=1. busy = stage-1 valid.
  - op = sext(incVal)×INC_MULT when inc=1.
  - op = −sext(decVal) when dec=1 and inc=0 (inc has priority).
  - Both inc and dec low: valid=0.
- Stage 2 (cycle N+1): if valid, acc[chan] <= acc[chan] + op, computed at OUT_WIDTH+1 bits.
  - Signed overflow (operand signs equal, result sign differs) sets ovf[chan]=1.
  - ovf stays set until clr, or clr_ch on that channel.
- Latency: strobe at edge N → accumulator updated at edge N+1 → visible on rd_q after edge N+2.
- Back-to-back updates to the same channel: each is applied in order, one per cycle. No stall, no hazard, because read-modify-write happens only in stage 2.
- clr_ch: registered with ch into stage 1 as a clear op.
  - In stage 2 it sets acc[chan]=0 and ovf[chan]=0.
  - clr_ch has priority over inc/dec presented in the same cycle; that inc/dec is dropped.
- Wrap-around: without saturation, the result is truncated to OUT_WIDTH (two's-complement wrap).
- rd_q <= acc[rd_ch] each cycle. It reflects the accumulator state after the previous edge's stage-2 update.
- −sext(decVal) with decVal = most-negative value is exact, since the operand is OUT_WIDTH wide and OUT_WIDTH > IN_WIDTH.

Optional Feature:
- Macro ACCUM_BANK_SATURATE_EN.
- Defined: on overflow, acc clamps to +2^(OUT_WIDTH−1)−1 (positive overflow) or −2^(OUT_WIDTH−1) (negative overflow). ovf is still set.
- Undefined: two's-complement wrap; ovf is set.

Decomposition:
- Package accum_bank_pkg:
  - op-kind enum: OP_NONE, OP_ADD, OP_CLR.
  - Function for signed overflow detection.
  - Saturation limit constants, derived from OUT_WIDTH.
- One sub-module: accum_bank_operand. It is the stage-1 operand generator (sign-extend, multiply, negate, priority) plus its pipeline register.

Test Plan (defaults: NUM_CH=4, OUT_WIDTH=16, INC_MULT=3):
1. clr=1 for 2 cycles, then idle → rd_q=0x0000, ovf=4'b0000, busy=0 for all rd_ch.
2. inc=1, incVal=8'h05, ch=0 for 1 cycle; rd_ch=0 → rd_q=15 (0x000F) two cycles after the strobe; busy=1 for exactly one cycle.
3. ch=1: dec, decVal=8'hFE (−2), then back-to-back inc, incVal=8'hFF (−1) → acc1=+2 then −1. rd_q: 0x0002, then 0xFFFF on consecutive cycles.
4. ch=2: inc, incVal=8'h7F repeated 86 times → 0x7FFE, ovf[2]=0. One more → 0x817B with ovf[2]=1 (wrap); with ACCUM_BANK_SATURATE_EN → 0x7FFF with ovf[2]=1.
5. Same cycle: inc and dec both high, incVal=1, decVal=1, ch=3 → acc3=+3 (inc priority). Then clr_ch with inc on ch=3 → acc3=0, ovf[3]=0; the inc is dropped.
6. Assert clr the cycle after an inc to ch=0 → the in-flight update is discarded; acc0=0, ovf=0, busy=0.
